case_convert_stream: RTL and testbench

- Registered, multi-lane, streaming successor to the combinational ASCII upper-case converter.
- Accepts LANES bytes per beat over a valid/ready stream.
- Applies a run-time selectable case mode per byte and presents the result one cycle later through an output register with back-pressure.
- Keeps a saturating count of bytes actually modified, for the text-processing path's status registers.

---
 rtl/case_convert_stream.sv | 147 ++++++++++++++
 tb/tb_case_convert_stream.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/case_convert_stream.sv
// case_convert_stream
// A streaming ASCII case converter. Each beat carries LANES bytes. Every byte
// gets the case mode that was selected when its beat was accepted. The
// converted beat comes out one cycle later from an output register that
// honours back-pressure. A saturating counter records how many bytes the
// conversion actually changed.
module case_convert_stream #(
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             mode,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [8*LANES-1:0]     s_data,
    input  logic [LANES-1:0]       s_keep,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [8*LANES-1:0]     m_data,
    output logic [LANES-1:0]       m_keep,
    input  logic                   clr_count,
    output logic [CNT_W-1:0]       conv_count
);

    localparam int DW    = 8 * LANES;
    localparam int LCW   = $clog2(LANES + 1);
    // One spare bit above the wider operand, so the sum can never wrap
    // before the saturation check sees it.
    localparam int SUM_W = ((CNT_W > LCW) ? CNT_W : LCW) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    localparam logic [1:0] MODE_PASS   = 2'b00;
    localparam logic [1:0] MODE_UPPER  = 2'b01;
    localparam logic [1:0] MODE_LOWER  = 2'b10;
    localparam logic [1:0] MODE_TOGGLE = 2'b11;

    logic [DW-1:0]    m_data_q,  m_data_d;
    logic [LANES-1:0] m_keep_q,  m_keep_d;
    logic             m_valid_q, m_valid_d;
    logic [CNT_W-1:0] count_q,   count_d;

    logic [DW-1:0]    conv_data;
    logic [LANES-1:0] lane_changed;
    logic [LCW-1:0]   changed_cnt;
    logic [SUM_W-1:0] count_sum;
    logic             accept;
    logic             transfer;

    // Reset forces s_ready low, so no beat can be accepted while rst is high.
    assign s_ready  = !rst && (!m_valid_q || m_ready);
    assign accept   = s_valid && s_ready;
    assign transfer = m_valid_q && m_ready;

    // Per-lane converters. Only the letter ranges are touched; every other
    // code, including bytes 128..255, passes through bit-exact.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : lane_g
            logic [7:0] in_byte;
            logic [7:0] out_byte;
            logic       is_lower;
            logic       is_upper;

            assign in_byte  = s_data[8*gi +: 8];
            assign is_lower = (in_byte >= 8'd97) && (in_byte <= 8'd122);
            assign is_upper = (in_byte >= 8'd65) && (in_byte <= 8'd90);

            // Select the converted byte for this lane from the active mode.
            always_comb begin
                out_byte = in_byte;
                if (s_keep[gi]) begin
                    case (mode)
                        MODE_UPPER:  if (is_lower) out_byte = in_byte - 8'd32;
                        MODE_LOWER:  if (is_upper) out_byte = in_byte + 8'd32;
                        MODE_TOGGLE: begin
                            if (is_lower)      out_byte = in_byte - 8'd32;
                            else if (is_upper) out_byte = in_byte + 8'd32;
                        end
                        default:     out_byte = in_byte;
                    endcase
                end
            end

            assign conv_data[8*gi +: 8] = out_byte;
            assign lane_changed[gi]     = (out_byte != in_byte);
        end
    endgenerate

    // Count the lanes whose byte was actually changed in this beat.
    always_comb begin
        changed_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            changed_cnt = changed_cnt + LCW'(lane_changed[i]);
        end
    end

    assign count_sum = SUM_W'(count_q) + SUM_W'(changed_cnt);

    // Next state for the output register and the saturating counter.
    always_comb begin
        m_data_d  = m_data_q;
        m_keep_d  = m_keep_q;
        m_valid_d = m_valid_q;
        count_d   = count_q;

        if (accept) begin
            m_data_d  = conv_data;
            m_keep_d  = s_keep;
            m_valid_d = 1'b1;
        end else if (transfer) begin
            m_valid_d = 1'b0;
        end

        // A clear takes priority, and the count from a beat accepted in the
        // same cycle is dropped.
        if (clr_count) begin
            count_d = '0;
        end else if (accept) begin
            if (count_sum > CNT_MAX) begin
                count_d = {CNT_W{1'b1}};
            end else begin
                count_d = count_sum[CNT_W-1:0];
            end
        end
    end

    // State registers. Reset drops any beat still held; that beat is not replayed.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_data_q  <= '0;
            m_keep_q  <= '0;
            m_valid_q <= 1'b0;
            count_q   <= '0;
        end else begin
            m_data_q  <= m_data_d;
            m_keep_q  <= m_keep_d;
            m_valid_q <= m_valid_d;
            count_q   <= count_d;
        end
    end

    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_keep     = m_keep_q;
    assign conv_count = count_q;

endmodule

// File: tb/tb_case_convert_stream.sv
// Testbench for case_convert_stream (LANES=4, CNT_W=4 so that saturation is
// reachable). Inputs are driven on the falling edge and outputs are sampled
// there. Expected beats go into a queue when they are driven and are popped
// when the DUT presents them.
module tb_case_convert_stream;

    localparam int LANES = 4;
    localparam int CNT_W = 4;
    localparam int CMAX  = 15;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [1:0]           mode = 2'b00;
    logic                 s_valid = 1'b0;
    logic                 s_ready;
    logic [8*LANES-1:0]   s_data = '0;
    logic [LANES-1:0]     s_keep = '0;
    logic                 m_valid;
    logic                 m_ready = 1'b1;
    logic [8*LANES-1:0]   m_data;
    logic [LANES-1:0]     m_keep;
    logic                 clr_count = 1'b0;
    logic [CNT_W-1:0]     conv_count;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp   = 0;
    int    n_bad   = 0;
    int    cnt_exp = 0;

    case_convert_stream #(.LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_keep     (s_keep),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_keep     (m_keep),
        .clr_count  (clr_count),
        .conv_count (conv_count)
    );

    always #5 clk = ~clk;

    // Reference conversion for one byte.
    function automatic logic [7:0] ref_byte(input logic [1:0] m, input logic [7:0] b);
        bit lo, up;
        lo = (b >= 8'd97) && (b <= 8'd122);
        up = (b >= 8'd65) && (b <= 8'd90);
        case (m)
            2'b01:   return lo ? b - 8'd32 : b;
            2'b10:   return up ? b + 8'd32 : b;
            2'b11:   return lo ? b - 8'd32 : (up ? b + 8'd32 : b);
            default: return b;
        endcase
    endfunction

    // Reference beat. Returns the number of bytes that changed.
    function automatic int ref_beat(input logic [1:0] m, input logic [31:0] d,
                                    input logic [3:0] k, output logic [31:0] o);
        int n = 0;
        logic [7:0] b;
        logic [7:0] nb;
        o = d;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) begin
                b  = d[8*i +: 8];
                nb = ref_byte(m, b);
                o[8*i +: 8] = nb;
                if (nb != b) n++;
            end
        end
        return n;
    endfunction

    // Drive a beat that will be accepted at the next rising edge. Record its
    // expected output and the expected count.
    task automatic drive_beat(input logic [1:0] m, input logic [31:0] d, input logic [3:0] k);
        logic [31:0] o;
        int n;
        n = ref_beat(m, d, k, o);
        exp_q.push_back('{data: o, keep: k});
        cnt_exp = (cnt_exp + n > CMAX) ? CMAX : cnt_exp + n;
        mode    = m;
        s_data  = d;
        s_keep  = k;
        s_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_valid = 1'b1;
        s_data = 32'h61626364;
        s_keep = 4'hf;
        mode = 2'b01;
        repeat (2) begin
            @(negedge clk);
            n_cmp++;
            if ({s_ready, m_valid, m_keep, m_data, conv_count} !== '0) begin
                n_bad++;
                $display("FAIL reset_state: rdy=%b vld=%b keep=%h data=%h cnt=%0d, required all zero",
                         s_ready, m_valid, m_keep, m_data, conv_count);
            end
        end
        s_valid = 1'b0;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: s_ready=%b m_valid=%b, required 1/0", s_ready, m_valid);
        end
        cnt_exp = 0;
    endtask

    task automatic test_modes();
        logic [1:0]  tm [4] = '{2'b01, 2'b01, 2'b10, 2'b11};
        logic [31:0] td [4] = '{{8'd122, 8'd65, 8'd97, 8'd40},
                                {8'd183, 8'd235, 8'd131, 8'd123},
                                {8'd72, 8'd71, 8'd109, 8'd48},
                                {8'd97, 8'd65, 8'd122, 8'd90}};
        beat_t e;
        @(negedge clk);
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_beat(tm[i], td[i], 4'hf);
            @(negedge clk);
            s_valid = 1'b0;
            e = exp_q.pop_front();
            n_cmp++;
            if ({m_valid, m_keep, m_data} !== {1'b1, e.keep, e.data}) begin
                n_bad++;
                $display("FAIL mode_beat%0d: vld=%b keep=%h data=%h, required 1 %h %h",
                         i, m_valid, m_keep, m_data, e.keep, e.data);
            end
            n_cmp++;
            if (conv_count !== CNT_W'(cnt_exp)) begin
                n_bad++;
                $display("FAIL mode_count%0d: got %0d, required %0d", i, conv_count, cnt_exp);
            end
        end
        // Literal cross-check on the first test-plan vector.
        n_cmp++;
        if (tm[0] == 2'b01 && ref_byte(2'b01, 8'd122) !== 8'd90) begin
            n_bad++;
            $display("FAIL ref_upper: got %0d, required 90", ref_byte(2'b01, 8'd122));
        end
    endtask

    task automatic test_keep();
        beat_t e;
        @(negedge clk);
        drive_beat(2'b01, {8'd97, 8'd98, 8'd99, 8'd100}, 4'b0101);
        @(negedge clk);
        s_valid = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if ({m_valid, m_keep, m_data} !== {1'b1, 4'b0101, 8'd97, 8'd66, 8'd99, 8'd68}) begin
            n_bad++;
            $display("FAIL keep_mask: vld=%b keep=%b data=%h, required 1 0101 %h",
                     m_valid, m_keep, m_data, e.data);
        end
        n_cmp++;
        if (conv_count !== CNT_W'(cnt_exp)) begin
            n_bad++;
            $display("FAIL keep_count: got %0d, required %0d", conv_count, cnt_exp);
        end
    endtask

    task automatic test_back_to_back();
        beat_t e;
        logic [31:0] b_data = 32'h484d6c30;
        @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
        m_ready = 1'b0;
        drive_beat(2'b11, 32'h61424364, 4'hf);
        @(negedge clk);
        // Beat B waits at the input while A is stalled at the output.
        mode = 2'b10;
        s_data = b_data;
        s_keep = 4'hf;
        s_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if (s_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL stall_ready%0d: got %b, required 0", c, s_ready);
            end
            n_cmp++;
            if ({m_valid, m_keep, m_data} !== {1'b1, exp_q[0].keep, exp_q[0].data}) begin
                n_bad++;
                $display("FAIL stall_hold%0d: vld=%b keep=%h data=%h, required 1 %h %h",
                         c, m_valid, m_keep, m_data, exp_q[0].keep, exp_q[0].data);
            end
            @(negedge clk);
        end
        m_ready = 1'b1;
        #1;
        n_cmp++;
        if (s_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL release_ready: got %b, required 1", s_ready);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if ({m_valid, m_data} !== {1'b1, e.data}) begin
            n_bad++;
            $display("FAIL release_beat: vld=%b data=%h, required 1 %h", m_valid, m_data, e.data);
        end
        drive_beat(2'b10, b_data, 4'hf);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if ({m_valid, m_keep, m_data} !== {1'b1, e.keep, e.data}) begin
                n_bad++;
                $display("FAIL b2b_beat%0d: vld=%b keep=%h data=%h, required 1 %h %h",
                         i, m_valid, m_keep, m_data, e.keep, e.data);
            end
            if (i < 4) begin
                drive_beat(2'($urandom_range(0, 3)), $urandom, 4'($urandom_range(1, 15)));
            end else begin
                s_valid = 1'b0;
            end
        end
        @(negedge clk);
        n_cmp++;
        if (m_valid !== 1'b0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL b2b_drain: m_valid=%b pending=%0d, required 0/0", m_valid, exp_q.size());
        end
        n_cmp++;
        if (conv_count !== CNT_W'(cnt_exp)) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d, required %0d", conv_count, cnt_exp);
        end
    endtask

    task automatic test_saturation();
        beat_t e;
        @(negedge clk);
        s_valid = 1'b0;
        clr_count = 1'b1;
        cnt_exp = 0;
        @(negedge clk);
        clr_count = 1'b0;
        n_cmp++;
        if (conv_count !== 4'd0) begin
            n_bad++;
            $display("FAIL clear_idle: got %0d, required 0", conv_count);
        end
        for (int i = 0; i < 5; i++) begin
            drive_beat(2'b01, 32'h61626364, 4'hf);
            @(negedge clk);
            s_valid = 1'b0;
            e = exp_q.pop_front();
            n_cmp++;
            if (conv_count !== CNT_W'(cnt_exp)) begin
                n_bad++;
                $display("FAIL sat_count%0d: got %0d, required %0d", i, conv_count, cnt_exp);
            end
        end
        n_cmp++;
        if (conv_count !== 4'd15) begin
            n_bad++;
            $display("FAIL sat_final: got %0d, required 15", conv_count);
        end
        // Clear together with a converting beat: the beat still passes, the count drops to zero.
        drive_beat(2'b01, 32'h77787980, 4'hf);
        clr_count = 1'b1;
        cnt_exp = 0;
        @(negedge clk);
        clr_count = 1'b0;
        s_valid = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if ({m_valid, m_data, conv_count} !== {1'b1, e.data, 4'd0}) begin
            n_bad++;
            $display("FAIL clear_with_beat: vld=%b data=%h cnt=%0d, required 1 %h 0",
                     m_valid, m_data, conv_count, e.data);
        end
    endtask

    task automatic test_reset_mid();
        beat_t e;
        @(negedge clk);
        m_ready = 1'b0;
        drive_beat(2'b01, 32'h61626364, 4'hf);
        @(negedge clk);
        s_valid = 1'b0;
        n_cmp++;
        if (m_valid !== 1'b1 || conv_count !== CNT_W'(cnt_exp)) begin
            n_bad++;
            $display("FAIL pre_reset: m_valid=%b cnt=%0d, required 1 %0d", m_valid, conv_count, cnt_exp);
        end
        rst = 1'b1;
        s_valid = 1'b1;
        #1;
        n_cmp++;
        if (s_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_in_reset: got %b, required 0", s_ready);
        end
        @(negedge clk);
        n_cmp++;
        if ({s_ready, m_valid, m_keep, m_data, conv_count} !== '0) begin
            n_bad++;
            $display("FAIL mid_reset: rdy=%b vld=%b keep=%h data=%h cnt=%0d, required all zero",
                     s_ready, m_valid, m_keep, m_data, conv_count);
        end
        exp_q.delete();
        cnt_exp = 0;
        s_valid = 1'b0;
        rst = 1'b0;
        m_ready = 1'b1;
        drive_beat(2'b11, 32'h5a7a2141, 4'hf);
        #1;
        n_cmp++;
        if (m_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_early: m_valid=%b before edge, required 0", m_valid);
        end
        @(negedge clk);
        s_valid = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if ({m_valid, m_keep, m_data, conv_count} !== {1'b1, e.keep, e.data, CNT_W'(cnt_exp)}) begin
            n_bad++;
            $display("FAIL post_reset_beat: vld=%b keep=%h data=%h cnt=%0d, required 1 %h %h %0d",
                     m_valid, m_keep, m_data, conv_count, e.keep, e.data, cnt_exp);
        end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_keep();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
